// File: rtl/bcd_serial_addsub.sv
// Digit-serial BCD adder/subtractor: operands latched on start, one digit per clock (LSD first),
// a one-cycle done pulse presents the result, carry/borrow and invalid-digit flag.
module bcd_serial_addsub #(
    parameter int unsigned DIGITS = 3
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic                  i_sub,
    input  logic [4*DIGITS-1:0]   i_a,
    input  logic [4*DIGITS-1:0]   i_b,
    input  logic                  i_cin,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [4*DIGITS-1:0]   o_s,
    output logic                  o_cout,
    output logic                  o_err
);

    localparam int unsigned W  = 4 * DIGITS;
    localparam int unsigned CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_t;

    state_t          r_state;
    state_t          w_state_d;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic            r_sub;
    logic            r_carry;
    logic [CW-1:0]   r_cnt;
    logic            r_inv;
    logic [W-1:0]    r_res;
    logic [W-1:0]    r_s;
    logic            r_cout;
    logic            r_err;

    logic            w_accept;
    logic            w_last;
    logic            w_inv;
    logic [3:0]      w_ak;
    logic [3:0]      w_bk;
    logic [3:0]      w_bk_adj;
    logic [4:0]      w_t;
    logic [4:0]      w_t6;
    logic            w_gt9;
    logic [3:0]      w_digit;
    logic [W-1:0]    w_res_next;

    assign w_accept = i_start && (r_state != StRun);
    assign w_last   = (r_state == StRun) && (r_cnt == LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle:  if (i_start) w_state_d = StRun;
            StRun:   if (w_last) w_state_d = StDone;
            StDone:  w_state_d = i_start ? StRun : StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    // Any digit of either operand above 9 poisons the whole operation.
    always_comb begin
        w_inv = 1'b0;
        for (int k = 0; k < int'(DIGITS); k++) begin
            if ((i_a[4*k +: 4] > 4'd9) || (i_b[4*k +: 4] > 4'd9)) begin
                w_inv = 1'b1;
            end
        end
    end

    // Subtraction uses nine's complement of b plus an initial carry of one.
    always_comb begin
        w_ak       = r_a[4*r_cnt +: 4];
        w_bk       = r_b[4*r_cnt +: 4];
        w_bk_adj   = r_sub ? (4'd9 - w_bk) : w_bk;
        w_t        = {1'b0, w_ak} + {1'b0, w_bk_adj} + {4'b0000, r_carry};
        w_gt9      = (w_t > 5'd9);
        w_t6       = w_t + 5'd6;
        w_digit    = w_gt9 ? w_t6[3:0] : w_t[3:0];
        w_res_next = r_res;
        w_res_next[4*r_cnt +: 4] = w_digit;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sub   <= 1'b0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_inv   <= 1'b0;
            r_res   <= '0;
            r_s     <= '0;
            r_cout  <= 1'b0;
            r_err   <= 1'b0;
        end else if (w_accept) begin
            r_a     <= i_a;
            r_b     <= i_b;
            r_sub   <= i_sub;
            r_carry <= i_sub ? 1'b1 : i_cin;
            r_cnt   <= '0;
            r_inv   <= w_inv;
            r_res   <= '0;
        end else if (r_state == StRun) begin
            r_res   <= w_res_next;
            r_carry <= w_gt9;
            r_cnt   <= w_last ? '0 : r_cnt + 1'b1;
            if (w_last) begin
                r_s    <= r_inv ? '0 : w_res_next;
                r_cout <= r_inv ? 1'b0 : w_gt9;
                r_err  <= r_inv;
            end
        end
    end

    assign o_busy = (r_state == StRun);
    assign o_done = (r_state == StDone);
    assign o_s    = r_s;
    assign o_cout = r_cout;
    assign o_err  = r_err;

endmodule

// File: tb/tb_bcd_serial_addsub.sv
// Randomised and directed bench for bcd_serial_addsub against a decimal-arithmetic reference.
module tb_bcd_serial_addsub;

    localparam int unsigned D = 3;
    localparam int unsigned W = 4 * D;
    localparam int          MOD = 10 ** D;

    logic          i_clk = 1'b0;
    logic          i_rst_n = 1'b0;
    logic          i_start = 1'b0;
    logic          i_sub = 1'b0;
    logic [W-1:0]  i_a = '0;
    logic [W-1:0]  i_b = '0;
    logic          i_cin = 1'b0;
    logic          o_busy;
    logic          o_done;
    logic [W-1:0]  o_s;
    logic          o_cout;
    logic          o_err;

    int            n_vec = 0;
    int            n_miss = 0;
    logic [W-1:0]  exp_s = '0;
    logic          exp_cout = 1'b0;
    logic          exp_err = 1'b0;

    bcd_serial_addsub #(.DIGITS(D)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_start (i_start),
        .i_sub   (i_sub),
        .i_a     (i_a),
        .i_b     (i_b),
        .i_cin   (i_cin),
        .o_busy  (o_busy),
        .o_done  (o_done),
        .o_s     (o_s),
        .o_cout  (o_cout),
        .o_err   (o_err)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int bcd2int(input logic [W-1:0] v);
        int r = 0;
        for (int i = D - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [W-1:0] int2bcd(input int x);
        logic [W-1:0] r = '0;
        for (int i = 0; i < D; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic bit has_inv(input logic [W-1:0] v);
        for (int i = 0; i < D; i++) if (v[4*i +: 4] > 4'd9) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model(input logic sub, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, output logic [W-1:0] s, output logic cout,
                         output logic err);
        int r;
        if (has_inv(a) || has_inv(b)) begin
            s = '0; cout = 1'b0; err = 1'b1;
        end else begin
            err = 1'b0;
            if (sub) begin
                r = bcd2int(a) - bcd2int(b);
                cout = (r >= 0);
                if (r < 0) r = r + MOD;
            end else begin
                r = bcd2int(a) + bcd2int(b) + int'(cin);
                cout = (r >= MOD);
                r = r % MOD;
            end
            s = int2bcd(r);
        end
    endtask

    task automatic check_result(input logic [W-1:0] es, input logic ec, input logic ee);
        check("s", o_s, es);
        check("cout", o_cout, ec);
        check("err", o_err, ee);
    endtask

    task automatic do_op(input logic sub, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin);
        logic [W-1:0] es;
        logic ec, ee;
        int busy_n, lat;
        model(sub, a, b, cin, es, ec, ee);
        @(negedge i_clk);
        i_sub = sub; i_a = a; i_b = b; i_cin = cin; i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        lat = 1; busy_n = 0;
        while (!o_done && lat < 20) begin
            if (o_busy) busy_n++;
            check_result(exp_s, exp_cout, exp_err);
            @(negedge i_clk);
            lat++;
        end
        check("done_seen", o_done, 1);
        check("latency", lat, D + 1);
        check("busy_cycles", busy_n, D);
        check("busy_at_done", o_busy, 0);
        check_result(es, ec, ee);
        exp_s = es; exp_cout = ec; exp_err = ee;
        @(negedge i_clk);
        check("done_pulse", o_done, 0);
    endtask

    function automatic logic [W-1:0] rand_opnd();
        logic [W-1:0] v;
        for (int i = 0; i < D; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
        if ($urandom_range(0, 15) == 0) v[4*$urandom_range(0, D-1) +: 4] = 4'($urandom_range(10, 15));
        return v;
    endfunction

    initial begin
        logic [W-1:0] es, va, vb;
        logic ec, ee;
        int dn;

        #1;
        check("rst_busy", o_busy, 0);
        check("rst_done", o_done, 0);
        check_result('0, 1'b0, 1'b0);
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;

        do_op(1'b0, 12'h002, 12'h003, 1'b0);
        do_op(1'b0, 12'h111, 12'h111, 1'b0);
        do_op(1'b0, 12'h888, 12'h333, 1'b0);
        do_op(1'b0, 12'h999, 12'h000, 1'b1);
        do_op(1'b1, 12'h500, 12'h123, 1'b0);
        do_op(1'b1, 12'h123, 12'h500, 1'b0);
        do_op(1'b1, 12'h000, 12'h000, 1'b1);
        do_op(1'b0, 12'h00A, 12'h001, 1'b0);
        do_op(1'b0, 12'h001, 12'h001, 1'b0);

        // Start pulsed during RUN with other operands must be ignored.
        model(1'b0, 12'h456, 12'h321, 1'b1, es, ec, ee);
        @(negedge i_clk);
        i_sub = 1'b0; i_a = 12'h456; i_b = 12'h321; i_cin = 1'b1; i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        @(negedge i_clk);
        i_sub = 1'b1; i_a = 12'h999; i_b = 12'h777; i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        dn = 0;
        while (!o_done && dn < 20) begin
            @(negedge i_clk);
            dn++;
        end
        check("ign_done", o_done, 1);
        check("ign_wait", dn, 1);
        check_result(es, ec, ee);
        exp_s = es; exp_cout = ec; exp_err = ee;

        // Start held high: a result every D+1 cycles.
        model(1'b1, 12'h742, 12'h198, 1'b0, es, ec, ee);
        @(negedge i_clk);
        i_sub = 1'b1; i_a = 12'h742; i_b = 12'h198; i_start = 1'b1;
        for (int cyc = 1; cyc <= 3 * (D + 1); cyc++) begin
            @(negedge i_clk);
            check("held_done", o_done, ((cyc % (D + 1)) == 0));
            if (o_done) check_result(es, ec, ee);
        end
        i_start = 1'b0;
        exp_s = es; exp_cout = ec; exp_err = ee;
        @(negedge i_clk);
        check("held_stop_done", o_done, 0);
        check("held_stop_busy", o_busy, 0);

        // Reset during the second RUN cycle.
        do_op(1'b0, 12'h135, 12'h246, 1'b0);
        @(negedge i_clk);
        i_sub = 1'b0; i_a = 12'h222; i_b = 12'h333; i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        @(negedge i_clk);
        i_rst_n = 1'b0;
        #1;
        check("mrst_busy", o_busy, 0);
        check("mrst_done", o_done, 0);
        check_result('0, 1'b0, 1'b0);
        exp_s = '0; exp_cout = 1'b0; exp_err = 1'b0;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        dn = 0;
        repeat (8) begin
            @(negedge i_clk);
            if (o_done) dn++;
        end
        check("mrst_no_done", dn, 0);
        do_op(1'b0, 12'h001, 12'h001, 1'b0);

        for (int n = 0; n < 300; n++) begin
            va = rand_opnd();
            vb = rand_opnd();
            do_op(1'($urandom_range(0, 1)), va, vb, 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/bcd_serial_addsub.md
# bcd_serial_addsub

Parametrised digit-serial BCD adder/subtractor; next generation of the team's combinational 3-digit BCD adder. Operands of DIGITS packed BCD digits are latched on a start handshake. One digit (LSD first) is processed per clock, so area is independent of width, and a one-cycle done pulse marks the result. Adds subtract mode (ten's complement), invalid-digit detection and a busy/done handshake for use in sequencer-driven datapaths.

## Interface
- DIGITS, 3, number of BCD digits per operand/result (≥1)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request; accepted when state is IDLE or DONE
- sub  in  1  0 = a+b+cin, 1 = a−b (cin ignored); latched on accept
- a  in  4*DIGITS  packed BCD operand, digit 0 = bits [3:0]; latched on accept
- b  in  4*DIGITS  packed BCD operand; latched on accept
- cin  in  1  carry-in (add mode only); latched on accept
- busy  out  1  high while in RUN
- done  out  1  one-cycle pulse, result valid
- s  out  4*DIGITS  packed BCD result, held until next accepted start completes
- cout  out  1  add: decimal carry out; sub: 1 = no borrow (a≥b)
- err  out  1  any latched digit of a or b > 9; valid with done, held with s

## Operation
- FSM states: IDLE, RUN, DONE. Reset → IDLE.
- IDLE/DONE, start=1: latch a, b, sub, cin. Digit counter ← 0, state ← RUN.
- IDLE/DONE, start=0: DONE → IDLE; IDLE stays.
- RUN: start ignored (no queueing, latched operands unchanged).
- Carry init: add → cin; sub → 1.
- Per RUN cycle, digit k: bk' = sub ? (9 − bk) : bk. t = ak + bk' + c (5-bit binary).
  - If t > 9: digit = (t + 6)[3:0], c ← 1.
  - Else: digit = t[3:0], c ← 0.
  - Digit is shifted into an internal result register; k increments.
- At k = DIGITS−1, final carry is captured and state ← DONE.
- Entering DONE: s ← internal result, cout ← final carry, err ← sticky invalid flag. done = 1 for exactly the DONE cycle.
- Invalid digit: flag set at latch if any ak or bk > 9. The computation still runs for full latency, but s is forced to all-zero and cout to 0 at DONE.
- Subtract with cout=0: s holds the ten's complement of |a−b| (e.g. 123−500 → 623).
- s, cout and err change only on entry to DONE. They are stable during RUN, including while a new operation is in progress.

## Timing
- Reset values: state IDLE, busy 0, done 0, s 0, cout 0, err 0, counter 0, internal registers 0.
- Start accepted at edge E0.
- busy = 1 from after E0 through the cycle before DONE, i.e. DIGITS cycles.
- done = 1 in the cycle after edge E(DIGITS); latency start→done = DIGITS+1 edges.
- Back-to-back: start=1 during DONE is accepted. The next done follows DIGITS+1 edges later, giving one op per DIGITS+1 cycles.
- rst_n low mid-RUN: immediate return to reset values, no done, prior s lost.
- start held high continuously: re-accepted in each DONE cycle.
- DIGITS=1: RUN lasts one cycle.

## Test plan
- DIGITS=3, add, a=002, b=003, cin=0 → done after 4 edges, s=005, cout=0, err=0; busy high exactly 3 cycles.
- Add 111+111 → s=222, cout=0. Add 888+333 → s=221, cout=1. Add 999+000 with cin=1 → s=000, cout=1.
- Sub 500−123 → s=377, cout=1. Sub 123−500 → s=623, cout=0. Sub 000−000 → s=000, cout=1.
- Invalid a=0x00A, b=001 → err=1, s=000, cout=0 at done. The following valid op 001+001 → err=0, s=002.
- Start pulsed again 1 cycle into RUN with different operands → ignored, original result returned. Start held high → consecutive results at 4-cycle spacing.
- rst_n asserted at the 2nd RUN cycle → all outputs 0 immediately, no done. A new op after release completes normally.
